// File: rtl/fp_mul_lanes.sv
// Multi-lane pipelined floating-point multiplier: flush-to-zero inputs, RNE or truncation,
// special-value handling and per-lane {invalid, overflow, underflow, inexact} flags.
module fp_mul_lanes #(
    parameter int I_EXP  = 8,
    parameter int I_MNT  = 23,
    parameter int I_DATA = I_EXP + I_MNT + 1,
    parameter int LANES  = 4,
    parameter int TAG_W  = 4,
    parameter int ROUND  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*I_DATA-1:0] idataA,
    input  logic [LANES*I_DATA-1:0] idataB,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*I_DATA-1:0] odata,
    output logic [TAG_W-1:0]        out_tag,
    output logic [LANES*4-1:0]      oflags
);
    localparam int EW = I_EXP + 2;
    localparam int MW = I_MNT + 1;
    localparam int PW = 2 * MW;
    localparam logic signed [EW-1:0] BIAS   = EW'((1 << (I_EXP - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX   = EW'((1 << I_EXP) - 1);
    localparam logic signed [EW-1:0] E_ONE  = EW'(1);
    localparam logic signed [EW-1:0] E_ZERO = '0;
    localparam logic [I_EXP-1:0]     EXP_ONES = '1;

    typedef enum logic [1:0] {CLS_FIN, CLS_ZERO, CLS_INF, CLS_NAN} cls_t;

    function automatic cls_t classify(input logic [I_DATA-1:0] a, input logic [I_DATA-1:0] b);
        logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        a_zero = (a[I_DATA-2 -: I_EXP] == '0);
        b_zero = (b[I_DATA-2 -: I_EXP] == '0);
        a_inf  = (a[I_DATA-2 -: I_EXP] == EXP_ONES) && (a[I_MNT-1:0] == '0);
        b_inf  = (b[I_DATA-2 -: I_EXP] == EXP_ONES) && (b[I_MNT-1:0] == '0);
        a_nan  = (a[I_DATA-2 -: I_EXP] == EXP_ONES) && (a[I_MNT-1:0] != '0);
        b_nan  = (b[I_DATA-2 -: I_EXP] == EXP_ONES) && (b[I_MNT-1:0] != '0);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return CLS_NAN;
        else if (a_inf || b_inf) return CLS_INF;
        else if (a_zero || b_zero) return CLS_ZERO;
        else return CLS_FIN;
    endfunction

    function automatic logic round_inc(input logic lsb, input logic guard, input logic sticky);
        return (ROUND != 0) && guard && (sticky || lsb);
    endfunction

    logic             advance;
    logic             vld_p0_q, vld_p1_q, vld_p2_q;
    logic [TAG_W-1:0] tag_p0_q, tag_p1_q, tag_p2_q;

    // A full output register blocks every stage at once; bubbles are not squeezed out.
    assign advance   = ~vld_p2_q | out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_p2_q;
    assign out_tag   = tag_p2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else if (advance) begin
            vld_p0_q <= in_valid;
            vld_p1_q <= vld_p0_q;
            vld_p2_q <= vld_p1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            tag_p0_q <= in_tag;
            tag_p1_q <= tag_p0_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) tag_p2_q <= '0;
        else if (advance && vld_p1_q) tag_p2_q <= tag_p1_q;
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [I_DATA-1:0]    a, b;
        logic                 sgn_p0_q, sgn_p1_q;
        cls_t                 cls_p0_q, cls_p1_q;
        logic [I_EXP-1:0]     ea_p0_q, eb_p0_q;
        logic [MW-1:0]        ma_p0_q, mb_p0_q;
        logic [PW-1:0]        prod_p1_q;
        logic signed [EW-1:0] exp_p1_q;
        logic signed [EW-1:0] exp_n, exp_r;
        logic [I_MNT-1:0]     frac;
        logic [I_MNT:0]       frac_inc;
        logic                 guard, sticky;
        logic [I_DATA-1:0]    res_d, res_p2_q;
        logic [3:0]           flg_d, flg_p2_q;

        assign a = idataA[k*I_DATA +: I_DATA];
        assign b = idataB[k*I_DATA +: I_DATA];

        // Stage p0: unpacked fields and special-case class
        always_ff @(posedge clk) begin
            if (advance) begin
                sgn_p0_q <= a[I_DATA-1] ^ b[I_DATA-1];
                cls_p0_q <= classify(a, b);
                ea_p0_q  <= a[I_DATA-2 -: I_EXP];
                eb_p0_q  <= b[I_DATA-2 -: I_EXP];
                ma_p0_q  <= {1'b1, a[I_MNT-1:0]};
                mb_p0_q  <= {1'b1, b[I_MNT-1:0]};
            end
        end

        // Stage p1: raw mantissa product and biased exponent sum
        always_ff @(posedge clk) begin
            if (advance) begin
                sgn_p1_q  <= sgn_p0_q;
                cls_p1_q  <= cls_p0_q;
                prod_p1_q <= PW'(ma_p0_q) * PW'(mb_p0_q);
                exp_p1_q  <= $signed({2'b00, ea_p0_q}) + $signed({2'b00, eb_p0_q}) - BIAS;
            end
        end

        always_comb begin
            if (prod_p1_q[PW-1]) begin
                frac   = prod_p1_q[PW-2 -: I_MNT];
                guard  = prod_p1_q[I_MNT];
                sticky = |prod_p1_q[I_MNT-1:0];
                exp_n  = exp_p1_q + E_ONE;
            end else begin
                frac   = prod_p1_q[PW-3 -: I_MNT];
                guard  = prod_p1_q[I_MNT-1];
                sticky = |prod_p1_q[I_MNT-2:0];
                exp_n  = exp_p1_q;
            end
            // A carry out of the fraction leaves it all-zero, i.e. mantissa 1.0 one binade up.
            frac_inc = {1'b0, frac} + (I_MNT+1)'(round_inc(frac[0], guard, sticky));
            exp_r    = frac_inc[I_MNT] ? exp_n + E_ONE : exp_n;
            res_d    = '0;
            flg_d    = '0;
            case (cls_p1_q)
                CLS_NAN: begin
                    res_d = {1'b0, EXP_ONES, 1'b1, {(I_MNT-1){1'b0}}};
                    flg_d = 4'b1000;
                end
                CLS_INF:  res_d = {sgn_p1_q, EXP_ONES, {I_MNT{1'b0}}};
                CLS_ZERO: res_d = {sgn_p1_q, {(I_DATA-1){1'b0}}};
                default: begin
                    if (exp_r >= EMAX) begin
                        res_d = {sgn_p1_q, EXP_ONES, {I_MNT{1'b0}}};
                        flg_d = 4'b0101;
                    end else if (exp_r <= E_ZERO) begin
                        res_d = {sgn_p1_q, {(I_DATA-1){1'b0}}};
                        flg_d = 4'b0011;
                    end else begin
                        res_d = {sgn_p1_q, exp_r[I_EXP-1:0], frac_inc[I_MNT-1:0]};
                        flg_d = {3'b000, guard | sticky};
                    end
                end
            endcase
        end

        // Stage p2: packed result and flags; only real transactions overwrite the output
        always_ff @(posedge clk) begin
            if (reset) begin
                res_p2_q <= '0;
                flg_p2_q <= '0;
            end else if (advance && vld_p1_q) begin
                res_p2_q <= res_d;
                flg_p2_q <= flg_d;
            end
        end

        assign odata[k*I_DATA +: I_DATA] = res_p2_q;
        assign oflags[k*4 +: 4]          = flg_p2_q;
    end
endmodule

// File: tb/tb_fp_mul_lanes.sv
// Directed bench for fp_mul_lanes: arithmetic vectors, specials, range, stall and reset behaviour.
module tb_fp_mul_lanes;
    logic         clk = 1'b0;
    logic         reset, in_valid, out_ready;
    logic [127:0] idataA, idataB;
    logic [3:0]   in_tag;
    logic         in_ready, out_valid, t_in_ready, t_out_valid;
    logic [127:0] odata, t_odata;
    logic [3:0]   out_tag, t_out_tag;
    logic [15:0]  oflags, t_oflags;
    int           n_chk = 0;
    int           n_fail = 0;

    logic [31:0] tbl [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

    always #5 clk = ~clk;

    fp_mul_lanes #(.ROUND(1)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .idataA(idataA), .idataB(idataB), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .odata(odata), .out_tag(out_tag), .oflags(oflags)
    );

    fp_mul_lanes #(.ROUND(0)) u_trunc (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(t_in_ready),
        .idataA(idataA), .idataB(idataB), .in_tag(in_tag),
        .out_valid(t_out_valid), .out_ready(out_ready),
        .odata(t_odata), .out_tag(t_out_tag), .oflags(t_oflags)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction with out_ready high; returns at the edge where the result is visible.
    task automatic xfer(input logic [127:0] a, input logic [127:0] b, input logic [3:0] tag);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        idataA    = a;
        idataB    = b;
        in_tag    = tag;
        #1;
        chk("xfer_in_ready", 128'(in_ready), 128'(1'b1));
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_c1", 128'(out_valid), 128'(1'b0));
        @(negedge clk);
        chk("lat_c2", 128'(out_valid), 128'(1'b0));
        @(negedge clk);
        chk("lat_c3", 128'(out_valid), 128'(1'b1));
        chk("xfer_tag", 128'(out_tag), 128'(tag));
    endtask

    task automatic drive_bp(input int i);
        for (int k = 0; k < 4; k++) idataA[k*32 +: 32] = tbl[(i + k) % 8];
        idataB = {32'hBF800000, 32'h3F800000, 32'h3F000000, 32'h40000000};
        in_tag = 4'(i);
    endtask

    // x2 bumps the exponent, x0.5 drops it, x1 keeps it, x-1 flips the sign.
    function automatic logic [127:0] bp_exp(input int i);
        logic [127:0] r;
        logic [31:0]  av;
        av = tbl[i % 8];         r[31:0]   = av + 32'h00800000;
        av = tbl[(i + 1) % 8];   r[63:32]  = av - 32'h00800000;
        av = tbl[(i + 2) % 8];   r[95:64]  = av;
        av = tbl[(i + 3) % 8];   r[127:96] = av ^ 32'h80000000;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, i_in, i_out, seen;
        logic         held;
        logic [127:0] h_data;
        logic [3:0]   h_tag;
        logic [15:0]  h_flg;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        idataA = '0; idataB = '0; in_tag = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
        chk("rst_odata", odata, 128'h0);
        chk("rst_out_tag", 128'(out_tag), 128'h0);
        chk("rst_oflags", 128'(oflags), 128'h0);

        xfer({32'h3FFFFFFF, 32'h3F800001, 32'hC0000000, 32'h3FC00000},
             {32'h3FFFFFFF, 32'h3F800001, 32'h40400000, 32'h40000000}, 4'h5);
        chk("basic_odata", odata, {32'h407FFFFE, 32'h3F800002, 32'hC0C00000, 32'h40400000});
        chk("basic_flags", 128'(oflags), 128'(16'h1100));
        chk("basic_trunc_odata", t_odata, {32'h407FFFFE, 32'h3F800002, 32'hC0C00000, 32'h40400000});
        chk("basic_trunc_flags", 128'(t_oflags), 128'(16'h1100));

        xfer({32'h3F800001, 32'hFF800000, 32'h7FC00000, 32'h7F800000},
             {32'h3FC00000, 32'h40000000, 32'h3F800000, 32'h00000000}, 4'hA);
        chk("spec_odata", odata, {32'h3FC00002, 32'hFF800000, 32'h7FC00000, 32'h7FC00000});
        chk("spec_flags", 128'(oflags), 128'(16'h1088));
        chk("spec_trunc_odata", t_odata, {32'h3FC00001, 32'hFF800000, 32'h7FC00000, 32'h7FC00000});

        xfer({32'h3F800003, 32'h00000001, 32'h00800000, 32'h7F000000},
             {32'h3FC00000, 32'h7F000000, 32'h3F000000, 32'h40000000}, 4'h3);
        chk("range_odata", odata, {32'h3FC00004, 32'h00000000, 32'h00000000, 32'h7F800000});
        chk("range_flags", 128'(oflags), 128'(16'h1035));
        chk("range_trunc_odata", t_odata, {32'h3FC00004, 32'h00000000, 32'h00000000, 32'h7F800000});
        chk("range_trunc_flags", 128'(t_oflags), 128'(16'h1035));

        xfer({32'h00000000, 32'hFFC00001, 32'h7F800000, 32'h80000000},
             {32'h7F800000, 32'h3F800000, 32'hFF800000, 32'h40000000}, 4'hC);
        chk("sign_odata", odata, {32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h80000000});
        chk("sign_flags", 128'(oflags), 128'(16'h8800));

        // Back-to-back stream with a forced 5-cycle stall and random backpressure.
        cyc = 0; i_in = 0; i_out = 0; held = 1'b0;
        h_data = '0; h_tag = '0; h_flg = '0;
        while (i_out < 8 && cyc < 300) begin
            @(negedge clk);
            if (held) begin
                chk("hold_valid", 128'(out_valid), 128'(1'b1));
                chk("hold_odata", odata, h_data);
                chk("hold_tag", 128'(out_tag), 128'(h_tag));
                chk("hold_flags", 128'(oflags), 128'(h_flg));
            end
            if (cyc < 5) out_ready = 1'b1;
            else if (cyc < 10) out_ready = 1'b0;
            else out_ready = 1'($urandom_range(0, 1));
            if (i_in < 8) begin
                in_valid = 1'b1;
                drive_bp(i_in);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            held = 1'b0;
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", 128'(in_ready), 128'(1'b0));
                held = 1'b1; h_data = odata; h_tag = out_tag; h_flg = oflags;
            end
            if (out_valid && out_ready) begin
                chk("bp_tag", 128'(out_tag), 128'(4'(i_out)));
                chk("bp_odata", odata, bp_exp(i_out));
                chk("bp_flags", 128'(oflags), 128'h0);
                i_out++;
            end
            if (in_valid && in_ready) i_in++;
            cyc++;
        end
        chk("bp_all_out", 128'(i_out), 128'(8));

        // Reset with two transactions in flight: neither may ever emerge.
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b1; drive_bp(1); in_tag = 4'hE;
        @(negedge clk);
        drive_bp(2); in_tag = 4'hF;
        @(negedge clk);
        in_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("midrst_in_ready", 128'(in_ready), 128'(1'b1));
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_no_emit", 128'(seen), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
